// File: rtl/i2c_hex_pkg.sv
// Shared types and helpers for the I2C register-access master and its hex display.
package i2c_hex_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_TX_BYTE,
        ST_RX_ACK,
        ST_RSTART,
        ST_RX_BYTE,
        ST_TX_NACK,
        ST_STOP,
        ST_DONE
    } state_e;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h20;
    localparam logic       RNW_WRITE    = 1'b0;
    localparam logic       RNW_READ     = 1'b1;

    // Address byte on the wire: 7-bit device address followed by R/nW.
    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rnw);
        return {dev, rnw};
    endfunction

    // Active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/clock_divider.sv
// Quarter-bit tick generator: one-clock enable every CLK_HZ/(4*I2C_HZ) clocks.
module clock_divider #(
    parameter int CLK_HZ = 50_000_000,
    parameter int I2C_HZ = 100_000
) (
    input  logic clk,
    input  logic reset,
    output logic i2c_tick
);
    localparam int            DIV  = CLK_HZ / (4 * I2C_HZ);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Wrap the counter on its last value; the tick marks that last value.
    always_comb begin
        cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        i2c_tick = (cnt_q == LAST);
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/i2c_hex_master.sv
// Single-transaction I2C register read/write master with six-digit hex status display.
module i2c_hex_master
    import i2c_hex_pkg::*;
#(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         I2C_HZ   = 100_000,
    parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       read,
    input  logic [7:0] reg_dest,
    input  logic [7:0] data_to_send,
    output logic [7:0] data_to_read,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    inout  wire        scl,
    inout  wire        sda,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);
    localparam logic [7:0] ADDR_WR = addr_byte(DEV_ADDR, RNW_WRITE);
    localparam logic [7:0] ADDR_RD = addr_byte(DEV_ADDR, RNW_READ);

    logic i2c_tick;

    clock_divider #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ)) u_div (
        .clk      (clk),
        .reset    (reset),
        .i2c_tick (i2c_tick)
    );

    state_e     state_q, state_d;
    logic [1:0] ph_q, ph_d;             // quarter-bit phase within the current SCL period
    logic [2:0] bit_cnt_q, bit_cnt_d;   // 7..0 in byte states, 1..0 for the two STOP periods
    logic [1:0] byte_idx_q, byte_idx_d; // 0: write address, 1: register, 2: data / read address
    logic       is_rd_q, is_rd_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_err_q, ack_err_d;
    logic       scl_low_q, scl_low_d;
    logic       sda_low_q, sda_low_d;
    logic       start_q, start_d;
    logic [1:0] sda_sync_q, sda_sync_d;

    logic start_edge, sda_in;
    assign start_edge = start & ~start_q;
    assign sda_in     = sda_sync_q[1];

    // Open-drain pads: only ever pull low or release.
    assign scl = scl_low_q ? 1'b0 : 1'bz;
    assign sda = sda_low_q ? 1'b0 : 1'bz;

    // State and datapath registers; reset releases the bus and aborts with no STOP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ph_q       <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            is_rd_q    <= 1'b0;
            reg_q      <= '0;
            wdata_q    <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
            ack_err_q  <= 1'b0;
            scl_low_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            start_q    <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            is_rd_q    <= is_rd_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            ack_err_q  <= ack_err_d;
            scl_low_q  <= scl_low_d;
            sda_low_q  <= sda_low_d;
            start_q    <= start_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    // Next-state and bus-phase sequencing; each bus state spans four ticks.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        is_rd_d    = is_rd_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;
        ack_err_d  = ack_err_q;
        scl_low_d  = scl_low_q;
        sda_low_d  = sda_low_q;
        start_d    = start;
        sda_sync_d = {sda_sync_q[0], sda};

        if (i2c_tick && state_q != ST_IDLE && state_q != ST_DONE) ph_d = ph_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
                if (start_edge) begin
                    state_d   = ST_START;
                    ph_d      = 2'd0;
                    is_rd_d   = read;
                    reg_d     = reg_dest;
                    wdata_d   = data_to_send;
                    ack_err_d = 1'b0;
                end
            end
            ST_START: if (i2c_tick) begin
                case (ph_q)
                    2'd0: sda_low_d = 1'b1;      // SDA falls with SCL high
                    2'd1: scl_low_d = 1'b1;
                    2'd3: begin
                        state_d    = ST_TX_BYTE;
                        tx_d       = ADDR_WR;
                        bit_cnt_d  = 3'd7;
                        byte_idx_d = 2'd0;
                    end
                    default: ;
                endcase
            end
            ST_TX_BYTE: if (i2c_tick) begin
                case (ph_q)
                    2'd0: sda_low_d = ~tx_q[7];
                    2'd1: scl_low_d = 1'b0;
                    2'd3: begin
                        scl_low_d = 1'b1;
                        tx_d      = {tx_q[6:0], 1'b0};
                        if (bit_cnt_q == 3'd0) state_d = ST_RX_ACK;
                        else                   bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                    default: ;
                endcase
            end
            ST_RX_ACK: if (i2c_tick) begin
                case (ph_q)
                    2'd0: sda_low_d = 1'b0;
                    2'd1: scl_low_d = 1'b0;
                    2'd2: if (sda_in) ack_err_d = 1'b1;
                    default: begin
                        scl_low_d = 1'b1;
                        bit_cnt_d = 3'd7;
                        if (ack_err_q) begin
                            state_d   = ST_STOP;
                            bit_cnt_d = 3'd1;
                        end else begin
                            case (byte_idx_q)
                                2'd0: begin
                                    state_d    = ST_TX_BYTE;
                                    tx_d       = reg_q;
                                    byte_idx_d = 2'd1;
                                end
                                2'd1: begin
                                    if (is_rd_q) state_d = ST_RSTART;
                                    else begin
                                        state_d    = ST_TX_BYTE;
                                        tx_d       = wdata_q;
                                        byte_idx_d = 2'd2;
                                    end
                                end
                                default: begin
                                    if (is_rd_q) state_d = ST_RX_BYTE;
                                    else begin
                                        state_d   = ST_STOP;
                                        bit_cnt_d = 3'd1;
                                    end
                                end
                            endcase
                        end
                    end
                endcase
            end
            ST_RSTART: if (i2c_tick) begin
                case (ph_q)
                    2'd0: sda_low_d = 1'b0;
                    2'd1: scl_low_d = 1'b0;
                    2'd2: sda_low_d = 1'b1;      // repeated START while SCL high
                    default: begin
                        scl_low_d  = 1'b1;
                        state_d    = ST_TX_BYTE;
                        tx_d       = ADDR_RD;
                        bit_cnt_d  = 3'd7;
                        byte_idx_d = 2'd2;
                    end
                endcase
            end
            ST_RX_BYTE: if (i2c_tick) begin
                case (ph_q)
                    2'd0: sda_low_d = 1'b0;
                    2'd1: scl_low_d = 1'b0;
                    2'd2: rx_d = {rx_q[6:0], sda_in};
                    default: begin
                        scl_low_d = 1'b1;
                        if (bit_cnt_q == 3'd0) state_d = ST_TX_NACK;
                        else                   bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                endcase
            end
            ST_TX_NACK: if (i2c_tick) begin
                case (ph_q)
                    2'd0: sda_low_d = 1'b0;      // NACK: leave SDA high
                    2'd1: scl_low_d = 1'b0;
                    2'd3: begin
                        scl_low_d = 1'b1;
                        state_d   = ST_STOP;
                        bit_cnt_d = 3'd1;
                    end
                    default: ;
                endcase
            end
            ST_STOP: if (i2c_tick) begin
                // First period forms the STOP; the second holds the bus free before DONE.
                if (bit_cnt_q == 3'd1) begin
                    case (ph_q)
                        2'd0: sda_low_d = 1'b1;
                        2'd1: scl_low_d = 1'b0;
                        2'd2: sda_low_d = 1'b0;  // SDA rises with SCL high
                        default: bit_cnt_d = 3'd0;
                    endcase
                end else if (ph_q == 2'd3) begin
                    state_d = ST_DONE;
                    if (is_rd_q && !ack_err_q) rdata_d = rx_q;
                end
            end
            default: state_d = ST_IDLE;      // ST_DONE lasts one clock
        endcase
    end

    // Status outputs and display; only the read-data digits depend on transaction state.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
        ack_error    = ack_err_q;
        data_to_read = rdata_q;
        HEX5         = hex7seg(reg_dest[7:4]);
        HEX4         = hex7seg(reg_dest[3:0]);
        HEX3         = hex7seg(data_to_send[7:4]);
        HEX2         = hex7seg(data_to_send[3:0]);
        HEX1         = hex7seg(rdata_q[7:4]);
        HEX0         = hex7seg(rdata_q[3:0]);
    end

endmodule

// File: tb/tb_i2c_hex_master.sv
// Bench for i2c_hex_master: bus-level slave/monitor plus transaction model.
module tb_i2c_hex_master;
    localparam int CLK_HZ = 4_000_000;
    localparam int I2C_HZ = 100_000;
    localparam int DIV    = CLK_HZ / (4 * I2C_HZ);
    localparam int PER    = 4 * DIV;
    localparam int EV_S   = 'h1000;
    localparam int EV_P   = 'h2000;
    localparam int AW     = 'h40;
    localparam int AR     = 'h41;
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, read = 1'b0;
    logic [7:0] reg_dest = 8'h11, data_to_send = 8'hAA;
    wire  [7:0] data_to_read;
    wire        busy, done, ack_error;
    wire  [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
    wire        scl_w, sda_w;
    pullup (scl_w);
    pullup (sda_w);
    logic slv_low = 1'b0;
    assign sda_w = slv_low ? 1'b0 : 1'bz;

    i2c_hex_master #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ), .DEV_ADDR(7'h20)) dut (
        .clk(clk), .reset(reset), .start(start), .read(read), .reg_dest(reg_dest),
        .data_to_send(data_to_send), .data_to_read(data_to_read), .busy(busy), .done(done),
        .ack_error(ack_error), .scl(scl_w), .sda(sda_w),
        .HEX5(HEX5), .HEX4(HEX4), .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
    );

    always #10 clk = ~clk;

    int errors = 0, checks = 0;
    logic [7:0] m_rd = 8'h00;   // model of data_to_read
    logic       m_ae = 1'b0;    // model of ack_error
    bit in_txn = 1'b1, chk_on = 1'b0;
    bit slv_en = 1'b1;
    logic [7:0] slv_data = 8'h00;
    int evq[$];

    task automatic summary_and_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
            if (errors >= 200) summary_and_finish();
        end
    endtask

    // Cycle-by-cycle comparison of display, read data and idle status against the model.
    initial begin
        forever begin
            @(negedge clk); #1;
            if (chk_on) begin
                chk("hex_digits", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0},
                    {SEG[reg_dest[7:4]], SEG[reg_dest[3:0]], SEG[data_to_send[7:4]],
                     SEG[data_to_send[3:0]], SEG[m_rd[7:4]], SEG[m_rd[3:0]]});
                chk("data_to_read", data_to_read, m_rd);
                if (!in_txn) chk("idle_status", {busy, done, ack_error}, {2'b00, m_ae});
            end
        end
    end

    // Bus monitor and register-slave model; logs START/STOP and {ack,byte} events.
    initial begin
        logic ps, pd, s, d, first, rdm;
        logic [7:0] sh;
        int nb;
        ps = 1; pd = 1; sh = 0; nb = 0; first = 0; rdm = 0;
        forever begin
            @(negedge clk);
            s = scl_w; d = sda_w;
            if (s && ps && pd && !d) begin
                evq.push_back(EV_S); nb = 0; first = 1; rdm = 0; slv_low = 0;
            end else if (s && ps && !pd && d) begin
                evq.push_back(EV_P); nb = 0; rdm = 0; slv_low = 0;
            end else if (s && !ps) begin
                if (nb < 8) begin
                    sh = {sh[6:0], d}; nb++;
                end else begin
                    evq.push_back(int'({d, sh}));
                    if (rdm) rdm = 0;
                    else if (first && sh[0] && !d) rdm = 1;
                    first = 0; nb = 0;
                end
            end else if (!s && ps) begin
                if (rdm && nb < 8)       slv_low = slv_en && !slv_data[7-nb];
                else if (!rdm && nb == 8) slv_low = slv_en;
                else                      slv_low = 0;
            end
            ps = s; pd = d;
        end
    end

    // One full transaction: drive the start edge, time it, then check outcome and bus bytes.
    task automatic run_txn(input bit rd, input logic [7:0] rg, input logic [7:0] wd,
                           input bit slv, input logic [7:0] sd, input bit extra_edge);
        int n_per, lat, first_fall, drops, lo, hi;
        int exp_ev[$];
        bit seen;
        slv_en = slv; slv_data = sd; read = rd; reg_dest = rg; data_to_send = wd;
        in_txn = 1;
        @(negedge clk);
        evq.delete();
        start = 1;
        n_per = !slv ? 12 : (rd ? 40 : 30);
        lat = 0; seen = 0; first_fall = -1; drops = 0;
        while (!seen && lat < (n_per + 4) * PER) begin
            @(negedge clk); lat++;
            if (lat == 3) start = 0;
            if (extra_edge && lat == 10 * PER) start = 1;
            if (extra_edge && lat == 10 * PER + 3) start = 0;
            if (lat == 1) chk("ack_error_cleared_on_accept", ack_error, 0);
            if (first_fall < 0 && sda_w == 1'b0) first_fall = lat;
            if (done) seen = 1;
            else if (!busy) drops++;
        end
        chk("done_seen", seen, 1);
        chk("busy_held_until_done", drops, 0);
        lo = n_per * PER - DIV - 1; hi = n_per * PER + 2;
        checks++;
        if (lat < lo || lat > hi) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles, expected %0d..%0d", lat, lo, hi);
        end
        checks++;
        if (first_fall < 1 || first_fall > DIV + 2) begin
            errors++;
            $display("FAIL start_to_sda_fall: got %0d cycles, expected 1..%0d", first_fall, DIV + 2);
        end
        m_ae = !slv;
        if (rd && slv) m_rd = sd;
        chk("ack_error_end", ack_error, m_ae);
        @(negedge clk);
        chk("done_one_cycle", {busy, done}, 0);
        in_txn = 0;
        repeat (2 * PER) @(negedge clk);
        if (!slv)     exp_ev = '{EV_S, 'h100 | AW, EV_P};
        else if (rd)  exp_ev = '{EV_S, AW, int'(rg), EV_S, AR, 'h100 | int'(sd), EV_P};
        else          exp_ev = '{EV_S, AW, int'(rg), int'(wd), EV_P};
        chk("bus_event_count", evq.size(), exp_ev.size());
        foreach (exp_ev[i])
            chk($sformatf("bus_event%0d", i), (i < evq.size()) ? evq[i] : -1, exp_ev[i]);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        summary_and_finish();
    end

    initial begin
        // reset held low with start idle
        repeat (150) @(negedge clk);
        #1;
        chk("rst_scl_released", scl_w, 1);
        chk("rst_sda_released", sda_w, 1);
        chk("rst_status", {busy, done, ack_error}, 0);
        chk("rst_data_to_read", data_to_read, 8'h00);
        chk("rst_hex5", HEX5, 7'h79);
        chk("rst_hex4", HEX4, 7'h79);
        chk("rst_hex3", HEX3, 7'h08);
        chk("rst_hex2", HEX2, 7'h08);
        chk("rst_hex1", HEX1, 7'h40);
        chk("rst_hex0", HEX0, 7'h40);
        chk_on = 1;
        @(negedge clk);
        reset = 1;
        repeat (5) @(negedge clk);
        in_txn = 0;

        // directed write, with literal pins on the logged bytes
        run_txn(1'b0, 8'h11, 8'hAA, 1'b1, 8'h00, 1'b0);
        chk("lit_write_b0", evq[1], 'h40);
        chk("lit_write_b1", evq[2], 'h11);
        chk("lit_write_b2", evq[3], 'hAA);
        chk("lit_write_ack_error", ack_error, 0);

        // directed read returning 0x5C
        run_txn(1'b1, 8'h11, 8'hAA, 1'b1, 8'h5C, 1'b0);
        chk("lit_read_data", data_to_read, 8'h5C);
        chk("lit_read_hex1", HEX1, 7'h12);
        chk("lit_read_hex0", HEX0, 7'h46);
        chk("lit_read_rstart", evq[3], EV_S);
        chk("lit_read_nack", evq[5], 'h15C);

        // no slave: NACK on the address byte, read data must not change
        run_txn(1'b1, 8'h11, 8'hAA, 1'b0, 8'h00, 1'b0);
        chk("lit_noslave_ack_error", ack_error, 1);
        chk("lit_noslave_data_kept", data_to_read, 8'h5C);

        // ack_error clears on the next accepted transaction
        run_txn(1'b0, 8'h3C, 8'h0F, 1'b1, 8'h00, 1'b0);

        // abort a read part-way through the register byte
        slv_en = 1; slv_data = 8'h33; read = 1; reg_dest = 8'h11; in_txn = 1;
        @(negedge clk); start = 1;
        repeat (3) @(negedge clk);
        start = 0;
        repeat (14 * PER + PER / 2) @(negedge clk);
        chk("busy_before_abort", busy, 1);
        reset = 0;
        @(posedge clk); #1;
        m_rd = 8'h00; m_ae = 1'b0;
        @(negedge clk);
        chk("abort_scl_released", scl_w, 1);
        chk("abort_sda_released", sda_w, 1);
        chk("abort_status", {busy, done, ack_error}, 0);
        chk("abort_data_to_read", data_to_read, 8'h00);
        reset = 1;
        repeat (2 * PER) @(negedge clk);
        in_txn = 0;

        // full transaction after the abort, then a second start edge while busy
        run_txn(1'b1, 8'hC7, 8'h21, 1'b1, 8'hB4, 1'b0);
        run_txn(1'b0, 8'h5A, 8'hE1, 1'b1, 8'h00, 1'b1);

        // randomized transactions
        for (int i = 0; i < 10; i++) begin
            run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        summary_and_finish();
    end

endmodule
